// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   // Handshake state reported by the RAM model.
   typedef enum logic [1:0] {
      RAM_FREE   = 2'd0,
      RAM_BUSY   = 2'd1,
      RAM_ACCESS = 2'd2,
      RAM_ERROR  = 2'd3
   } ramstate_t;

   // Arbiter FSM states: idle, fetch granted, data granted.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_IGRANT = 2'd1,
      ARB_DGRANT = 2'd2
   } arb_state_t;

   localparam int unsigned MAX_DSTREAK_DEF = 4;
   localparam int unsigned TIMEOUT_DEF     = 64;

   // A data access is requested by either a read or a write strobe.
   function automatic logic f_data_req(input logic ren, input logic wen);
      return ren | wen;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side requester signals and the RAM-side port.
// slave: the arbiter; master: the environment (CPU side + RAM model).
interface mem_arbiter_if;

   logic                          halt;
   logic                          iren;
   mem_arbiter_pkg::word_t        iaddr;
   logic                          iwait;
   mem_arbiter_pkg::word_t        iload;
   logic                          dren;
   logic                          dwen;
   mem_arbiter_pkg::word_t        daddr;
   mem_arbiter_pkg::word_t        dstore;
   logic                          dwait;
   mem_arbiter_pkg::word_t        dload;
   logic                          ramren;
   logic                          ramwen;
   mem_arbiter_pkg::word_t        ramaddr;
   mem_arbiter_pkg::word_t        ramstore;
   mem_arbiter_pkg::word_t        ramload;
   mem_arbiter_pkg::ramstate_t    ramstate;
   logic                          err;

   modport slave (
      input  halt, iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore, err
   );

   modport master (
      output halt, iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore, err
   );

endinterface

// File: rtl/mem_arbiter_arb_fairness_ctr.sv
// Fairness streak counter and grant watchdog for mem_arbiter.
// streak counts completed data grants since the last completed fetch;
// wdog counts the cycles of the current grant (1 in its first cycle).
module arb_fairness_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enter_grant,
   input  logic i_in_grant,
   input  logic i_leave_grant,
   input  logic i_data_done,
   input  logic i_fetch_done,
   output logic o_force_fetch,
   output logic o_timeout
);

   localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
   localparam int unsigned WDOG_W   = $clog2(TIMEOUT);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
   localparam logic [WDOG_W-1:0]   WDOG_MAX   = WDOG_W'(TIMEOUT - 1);
   localparam logic [WDOG_W-1:0]   WDOG_ONE   = WDOG_W'(1);

   logic [STREAK_W-1:0] r_streak;
   logic [WDOG_W-1:0]   r_wdog;

   // Streak: saturating count of data completions, cleared by a fetch completion.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_streak <= '0;
      end else if (i_fetch_done) begin
         r_streak <= '0;
      end else if (i_data_done && (r_streak != STREAK_MAX)) begin
         r_streak <= r_streak + STREAK_ONE;
      end else begin
         r_streak <= r_streak;
      end
   end

   // Watchdog: loads 1 when a grant starts so it equals the grant cycle number;
   // saturates at TIMEOUT-1 and clears whenever no grant is held.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wdog <= '0;
      end else if (i_enter_grant) begin
         r_wdog <= WDOG_ONE;
      end else if (i_in_grant && !i_leave_grant) begin
         r_wdog <= (r_wdog == WDOG_MAX) ? r_wdog : r_wdog + WDOG_ONE;
      end else begin
         r_wdog <= '0;
      end
   end

   assign o_force_fetch = (r_streak == STREAK_MAX);
   assign o_timeout     = i_in_grant && (r_wdog == WDOG_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data access.
// Data has priority unless the fairness counter forces a pending fetch.
// Grants are held until the RAM reports ACCESS or the requester drops.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   mem_arbiter_if.slave  bus
);

   arb_state_t r_state;
   arb_state_t w_next_state;
   logic       r_err;

   logic  w_ireq, w_dreq, w_access;
   logic  w_in_grant, w_enter_grant, w_leave_grant;
   logic  w_fetch_done, w_data_done;
   logic  w_force_fetch, w_timeout;
   logic  w_iwait, w_dwait, w_ramren, w_ramwen;
   word_t w_iload, w_dload, w_ramaddr, w_ramstore;

   assign w_ireq   = bus.iren & ~bus.halt;
   assign w_dreq   = f_data_req(bus.dren, bus.dwen);
   assign w_access = (bus.ramstate == RAM_ACCESS);

   // halt is deliberately not part of the fetch-done term: a fetch already
   // granted runs to completion even if halt rises during it.
   assign w_fetch_done  = (r_state == ARB_IGRANT) && bus.iren && w_access;
   assign w_data_done   = (r_state == ARB_DGRANT) && w_dreq && w_access;
   assign w_in_grant    = (r_state != ARB_IDLE);
   assign w_enter_grant = !w_in_grant && (w_next_state != ARB_IDLE);
   assign w_leave_grant = w_in_grant && (w_next_state == ARB_IDLE);

   arb_fairness_ctr #(
      .MAX_DSTREAK (MAX_DSTREAK),
      .TIMEOUT     (TIMEOUT)
   ) u_fair (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_enter_grant (w_enter_grant),
      .i_in_grant    (w_in_grant),
      .i_leave_grant (w_leave_grant),
      .i_data_done   (w_data_done),
      .i_fetch_done  (w_fetch_done),
      .o_force_fetch (w_force_fetch),
      .o_timeout     (w_timeout)
   );

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Sticky timeout flag: set when the watchdog expires without ACCESS.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_timeout && !w_access) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   // Next-state selection and the RAM/requester output mux for the granted side.
   always_comb begin
      w_next_state = r_state;
      w_iwait      = 1'b1;
      w_dwait      = 1'b1;
      w_iload      = 32'd0;
      w_dload      = 32'd0;
      w_ramren     = 1'b0;
      w_ramwen     = 1'b0;
      w_ramaddr    = 32'd0;
      w_ramstore   = 32'd0;
      case (r_state)
         ARB_IDLE: begin
            if (w_dreq && !(w_force_fetch && w_ireq)) begin
               w_next_state = ARB_DGRANT;
            end else if (w_ireq) begin
               w_next_state = ARB_IGRANT;
            end else begin
               w_next_state = ARB_IDLE;
            end
         end
         ARB_IGRANT: begin
            if (bus.iren) begin
               w_ramren  = 1'b1;
               w_ramaddr = bus.iaddr;
               if (w_access) begin
                  w_iwait      = 1'b0;
                  w_iload      = bus.ramload;
                  w_next_state = ARB_IDLE;
               end else begin
                  w_next_state = ARB_IGRANT;
               end
            end else begin
               w_next_state = ARB_IDLE;
            end
         end
         ARB_DGRANT: begin
            if (w_dreq) begin
               // dREN together with dWEN is treated as a write.
               w_ramren   = ~bus.dwen;
               w_ramwen   = bus.dwen;
               w_ramaddr  = bus.daddr;
               w_ramstore = bus.dstore;
               if (w_access) begin
                  w_dwait      = 1'b0;
                  w_dload      = bus.ramload;
                  w_next_state = ARB_IDLE;
               end else begin
                  w_next_state = ARB_DGRANT;
               end
            end else begin
               w_next_state = ARB_IDLE;
            end
         end
         default: begin
            w_next_state = ARB_IDLE;
         end
      endcase
   end

   assign bus.iwait    = w_iwait;
   assign bus.iload    = w_iload;
   assign bus.dwait    = w_dwait;
   assign bus.dload    = w_dload;
   assign bus.ramren   = w_ramren;
   assign bus.ramwen   = w_ramwen;
   assign bus.ramaddr  = w_ramaddr;
   assign bus.ramstore = w_ramstore;
   assign bus.err      = r_err;

endmodule
